// File: rtl/button_event_sequencer.sv
// Debounces the front-panel power and reset buttons into one-cycle press/release interrupt pulses.
// The long power-hold override is built only when BUTTON_LONG_PRESS_EN is defined.
module button_event_sequencer #(
  parameter int TICK_DIV      = 33000,
  parameter int DEBOUNCE_MS   = 16,
  parameter int LONG_PRESS_MS = 4000
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       PowerButtonN,
  input  logic       ResetButtonN,
  output logic [3:0] Interrupt,
  output logic [1:0] ButtonLevel,
  output logic       PowerOverride
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } state_t;

  localparam int          BTN_RST   = 0;
  localparam int          BTN_PWR   = 1;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_MS - 1);

  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  logic [1:0]  pressed;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        tick;
  state_t      state_q [2];
  state_t      state_d [2];
  logic [7:0]  db_cnt_q [2];
  logic [7:0]  db_cnt_d [2];
  logic [1:0]  press_evt;
  logic [1:0]  release_evt;
  logic [3:0]  interrupt_q, interrupt_d;

  // Bit 1 carries the power button and bit 0 the reset button throughout.
  always_comb begin
    sync1_d = {PowerButtonN, ResetButtonN};
    sync2_d = sync1_q;
    pressed = ~sync2_q;
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
  end

  // A level change always wins over a tick arriving in the same cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b]     = state_q[b];
      db_cnt_d[b]    = db_cnt_q[b];
      press_evt[b]   = 1'b0;
      release_evt[b] = 1'b0;
      case (state_q[b])
        RELEASED: begin
          if (pressed[b]) begin
            state_d[b]  = PRESS_DB;
            db_cnt_d[b] = 8'd0;
          end
        end
        PRESS_DB: begin
          if (!pressed[b]) begin
            state_d[b] = RELEASED;
          end else if (tick) begin
            if (db_cnt_q[b] == DB_LAST) begin
              state_d[b]   = PRESSED;
              press_evt[b] = 1'b1;
            end else begin
              db_cnt_d[b] = db_cnt_q[b] + 8'd1;
            end
          end
        end
        PRESSED: begin
          if (!pressed[b]) begin
            state_d[b]  = RELEASE_DB;
            db_cnt_d[b] = 8'd0;
          end
        end
        RELEASE_DB: begin
          if (pressed[b]) begin
            state_d[b] = PRESSED;
          end else if (tick) begin
            if (db_cnt_q[b] == DB_LAST) begin
              state_d[b]     = RELEASED;
              release_evt[b] = 1'b1;
            end else begin
              db_cnt_d[b] = db_cnt_q[b] + 8'd1;
            end
          end
        end
      endcase
    end
    interrupt_d = {press_evt[BTN_PWR], release_evt[BTN_PWR],
                   press_evt[BTN_RST], release_evt[BTN_RST]};
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      tick_cnt_q  <= 16'd0;
      interrupt_q <= 4'd0;
      for (int b = 0; b < 2; b++) begin
        state_q[b]  <= RELEASED;
        db_cnt_q[b] <= 8'd0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_cnt_q  <= tick_cnt_d;
      interrupt_q <= interrupt_d;
      for (int b = 0; b < 2; b++) begin
        state_q[b]  <= state_d[b];
        db_cnt_q[b] <= db_cnt_d[b];
      end
    end
  end

  always_comb begin
    ButtonLevel = 2'b00;
    for (int b = 0; b < 2; b++) begin
      ButtonLevel[b] = (state_q[b] == PRESSED) || (state_q[b] == RELEASE_DB);
    end
  end

  assign Interrupt = interrupt_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [11:0] HOLD_MAX = 12'(LONG_PRESS_MS);

  logic [11:0] hold_q, hold_d;
  logic        override_q, override_d;
  logic        pwr_held;
  logic        pwr_enter_pressed;

  // The held guard keeps a stale count from a previous press from firing on re-entry.
  always_comb begin
    pwr_held          = (state_q[BTN_PWR] == PRESSED) || (state_q[BTN_PWR] == RELEASE_DB);
    pwr_enter_pressed = (state_d[BTN_PWR] == PRESSED) && (state_q[BTN_PWR] != PRESSED);
    hold_d            = hold_q;
    if (pwr_enter_pressed) begin
      hold_d = 12'd0;
    end else if (tick && pwr_held && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 12'd1;
    end
    override_d = (override_q || (pwr_held && (hold_q == HOLD_MAX))) &&
                 (state_d[BTN_PWR] != RELEASED);
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      hold_q     <= 12'd0;
      override_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      override_q <= override_d;
    end
  end

  assign PowerOverride = override_q;
`else
  logic unused_long_press;

  assign unused_long_press = |12'(LONG_PRESS_MS);
  assign PowerOverride     = 1'b0;
`endif

endmodule

// File: doc/button_event_sequencer.md
# button_event_sequencer

Debounces the front-panel power and reset buttons and turns them into the single-cycle press/release event vector consumed by the LPC interrupt controller. It uses a shared millisecond tick to qualify every edge, and runs an independent four-state sequencer per button. It also detects a long power-button hold and raises a forced power-off request. Sits in the Control hierarchy under Lpc, beside the interrupt controller, and drives its 4-bit `Interrupt` input directly.

## Interface
Parameters:
- TICK_DIV, 33000 — LpcClock cycles per tick (1 ms at 33 MHz); legal 2..65535.
- DEBOUNCE_MS, 16 — stable ticks required to accept an edge; legal 1..255.
- LONG_PRESS_MS, 4000 — ticks the power button must be held before PowerOverride; legal 1..4095.

Ports:
- LpcClock  in  1  33 MHz clock.
- PciReset  in  1  reset, asynchronous, active-low.
- PowerButtonN  in  1  raw power button, active-low, asynchronous to LpcClock.
- ResetButtonN  in  1  raw reset button, active-low, asynchronous.
- Interrupt  out  4  {PowerInterrupt, PowerRelease, ResetInterrupt, ResetRelease}; one-cycle pulses.
- ButtonLevel  out  2  {PowerPressed, ResetPressed}; debounced levels, 1 = pressed.
- PowerOverride  out  1  long-hold forced-off request, level.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer; sync flops reset to 1 (released).
- **Tick generator:** 16-bit counter, wraps at TICK_DIV-1. `Tick` is a one-cycle pulse on the wrap and is shared by both buttons.
- **Per-button FSM** (sync level `P`, 1 = pressed; 8-bit debounce counter `DbCnt`):
  - RELEASED: `P`=1 → PRESS_DB, `DbCnt`=0.
  - PRESS_DB: `P`=0 → RELEASED, no event (glitch). Tick with `DbCnt`==DEBOUNCE_MS-1 → PRESSED and pulse the press bit. Any other tick → `DbCnt`+1.
  - PRESSED: `P`=0 → RELEASE_DB, `DbCnt`=0.
  - RELEASE_DB: `P`=1 → PRESSED, no event. Tick with `DbCnt`==DEBOUNCE_MS-1 → RELEASED and pulse the release bit. Any other tick → `DbCnt`+1.
- **Transition priority:** the level check has priority over a same-cycle tick.
- **Debounced levels:** ButtonLevel bit = 1 in PRESSED and RELEASE_DB.
- **Independence:** the two FSMs are fully independent. Press or release pulses of both buttons may coincide in one cycle; all asserted bits appear together.
- **Hold counter:** power button only, 12 bits. It clears on entry to PRESSED and increments on each tick while in PRESSED or RELEASE_DB. It saturates at LONG_PRESS_MS.
- **PowerOverride:** asserts the cycle after the hold counter reaches LONG_PRESS_MS. It stays asserted until the FSM enters RELEASED, and clears in the same cycle as the PowerRelease pulse.
- **Reset:** PciReset low → all FSMs RELEASED, all counters 0, Interrupt=0, ButtonLevel=0, PowerOverride=0.
- **Button held across reset:** a button held when reset deasserts goes through PRESS_DB normally and yields one press event.

## Timing
- Pin to sync level: 2 cycles.
- Sync level to event pulse: DEBOUNCE_MS ticks, counting the first tick after entering the DB state. That is (DEBOUNCE_MS-1)·TICK_DIV+1 to DEBOUNCE_MS·TICK_DIV cycles.
- Interrupt bits are registered: high exactly one cycle per accepted edge, never two consecutive cycles.
- ButtonLevel changes in the same cycle as the corresponding pulse.
- PowerOverride: LONG_PRESS_MS ticks after entry to PRESSED, plus 1 cycle.
- A bounce shorter than one full debounce window produces no event and no ButtonLevel change.

## Configuration
- **`BUTTON_LONG_PRESS_EN` defined:** hold counter and PowerOverride are implemented as above.
- **Not defined:** hold counter is removed, PowerOverride is tied to 0, and LONG_PRESS_MS is ignored. All other behaviour is identical.

## Test plan
Use TICK_DIV=4, DEBOUNCE_MS=3, LONG_PRESS_MS=10, with `BUTTON_LONG_PRESS_EN` defined, except where noted.
- **Clean press:** PowerButtonN low for 40 cycles → exactly one Interrupt=4'b1000 pulse, 2 sync cycles plus 9–12 cycles after the pin edge. ButtonLevel[1]=1 from the same cycle.
- **Glitch:** ResetButtonN low for 6 cycles, then high → Interrupt stays 0 and ButtonLevel stays 0.
- **Simultaneous release:** both buttons pressed and accepted, then both released on the same cycle → a single cycle with Interrupt=4'b0101, and ButtonLevel returns to 0.
- **Long press:** power held 60 cycles → PowerOverride=1 from 10 ticks after PRESSED, plus 1 cycle. On release, PowerOverride clears in the same cycle as Interrupt=4'b0100.
- **Reset mid-debounce:** PciReset low during PRESS_DB → all outputs 0 immediately. With the button still held after reset release, exactly one press pulse follows.
- **Macro off:** repeat the long-press scenario with `BUTTON_LONG_PRESS_EN` undefined → PowerOverride is never asserted, and the press/release pulses are unchanged.
